// File: rtl/enum_type.sv
// Shared command/state encodings for the Tetris engine and its command scheduler.
package enum_type;

    typedef enum logic [2:0] {
        NONE   = 3'd0,
        WAIT   = 3'd1,
        LEFT   = 3'd2,
        RIGHT  = 3'd3,
        DOWN   = 3'd4,
        DROP   = 3'd5,
        ROTATE = 3'd6,
        MOVE   = 3'd7
    } state_type;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } gs_state_t;

    // Player commands that move the piece down and so restart the gravity period.
    function automatic logic is_down_move(input state_type c);
        return (c == DOWN) || (c == DROP);
    endfunction

endpackage

// File: rtl/gravity_timer.sv
// Level-dependent gravity timer: counts clk cycles and raises a single pending
// tick each period; the pending flag saturates at one outstanding tick.
module gravity_timer
    import enum_type::*;
#(
    parameter int BASE_PERIOD = 100_000_000,
    parameter int STEP        = 6_000_000,
    parameter int MIN_PERIOD  = 5_000_000,
    parameter int PW          = $clog2(BASE_PERIOD + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [3:0]    level,
    input  logic          pause,
    input  logic          clr,
    input  logic          take,
    output logic          tick_pending
);

    localparam int EW = PW + 4;
    localparam logic [EW-1:0] BASE_EXT = EW'(BASE_PERIOD);
    localparam logic [EW-1:0] MIN_EXT  = EW'(MIN_PERIOD);

    logic [EW-1:0] reduction;
    logic [EW-1:0] period_calc;
    logic [PW-1:0] period_next;
    logic [PW-1:0] period_q;
    logic [PW-1:0] cnt;
    logic          tick;

    // Wide arithmetic so a large level*STEP clamps to zero instead of wrapping.
    always_comb begin
        reduction = EW'(level) * EW'(STEP);
        if (reduction >= BASE_EXT) begin
            period_calc = '0;
        end else begin
            period_calc = BASE_EXT - reduction;
        end
        if (period_calc < MIN_EXT) begin
            period_calc = MIN_EXT;
        end
        period_next = PW'(period_calc);
        tick        = !pause && (cnt >= period_q - PW'(1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q     <= PW'(BASE_PERIOD);
            cnt          <= '0;
            tick_pending <= 1'b0;
        end else begin
            period_q <= period_next;
            if (clr) begin
                cnt          <= '0;
                tick_pending <= 1'b0;
            end else if (!pause) begin
                cnt <= tick ? '0 : cnt + PW'(1);
                // A tick landing while one is already pending is simply lost.
                if (take) begin
                    tick_pending <= 1'b0;
                end else if (tick) begin
                    tick_pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gravity_sched.sv
// Arbitrates gravity DOWN ticks against player commands and hands exactly one
// command at a time to the game engine, holding it until accepted.
module gravity_sched
    import enum_type::*;
#(
    parameter int BASE_PERIOD = 100_000_000,
    parameter int STEP        = 6_000_000,
    parameter int MIN_PERIOD  = 5_000_000,
    parameter int PW          = $clog2(BASE_PERIOD + 1)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  state_type  usr_cmd,
    output logic       usr_pop,
    input  state_type  state,
    output state_type  cmd,
    input  logic [3:0] level,
    input  logic       pause,
    output logic       grav_pending
);

    gs_state_t fsm;
    logic      can_issue;
    logic      take;
    logic      issue_usr;
    logic      clr;

    // Gravity wins over the player; the timer sees take/clr in the issue cycle.
    always_comb begin
        can_issue = (fsm == IDLE) && !pause && (state == WAIT);
        take      = can_issue && grav_pending;
        issue_usr = can_issue && !grav_pending && (usr_cmd != NONE);
        clr       = issue_usr && is_down_move(usr_cmd);
    end

    gravity_timer #(
        .BASE_PERIOD (BASE_PERIOD),
        .STEP        (STEP),
        .MIN_PERIOD  (MIN_PERIOD),
        .PW          (PW)
    ) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .level        (level),
        .pause        (pause),
        .clr          (clr),
        .take         (take),
        .tick_pending (grav_pending)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm     <= IDLE;
            cmd     <= NONE;
            usr_pop <= 1'b0;
        end else begin
            usr_pop <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (take) begin
                        cmd <= DOWN;
                        fsm <= ISSUE;
                    end else if (issue_usr) begin
                        cmd     <= usr_cmd;
                        usr_pop <= 1'b1;
                        fsm     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (state != WAIT) begin
                        cmd <= NONE;
                        fsm <= BUSY;
                    end
                end
                BUSY: begin
                    if (state == WAIT) begin
                        fsm <= IDLE;
                    end
                end
                default: begin
                    cmd <= NONE;
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gravity_sched.sv
// Directed bench for gravity_sched with a short gravity period (20/4/8) and a
// one-cycle-accept engine model folded into the step task.
module tb_gravity_sched;
    import enum_type::*;

    logic       clk = 1'b0;
    logic       reset_n;
    state_type  usr_cmd;
    state_type  state;
    state_type  cmd;
    logic       usr_pop;
    logic [3:0] level;
    logic       pause;
    logic       grav_pending;

    int compared   = 0;
    int mismatched = 0;
    int pops       = 0;
    bit auto_eng   = 1'b1;

    always #5 clk = ~clk;

    gravity_sched #(
        .BASE_PERIOD (20),
        .STEP        (4),
        .MIN_PERIOD  (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .usr_cmd      (usr_cmd),
        .usr_pop      (usr_pop),
        .state        (state),
        .cmd          (cmd),
        .level        (level),
        .pause        (pause),
        .grav_pending (grav_pending)
    );

    // One clock; the engine accepts a presented command and returns to WAIT a cycle later.
    task automatic step;
        @(posedge clk);
        #1;
        pops += int'(usr_pop);
        if (auto_eng) begin
            if (state == WAIT && cmd != NONE) state = MOVE;
            else if (state == MOVE)           state = WAIT;
        end
        if (usr_pop) usr_cmd = NONE;
    endtask

    task automatic start(input logic [3:0] lvl);
        reset_n  = 1'b0;
        usr_cmd  = NONE;
        state    = WAIT;
        level    = lvl;
        pause    = 1'b0;
        auto_eng = 1'b1;
        pops     = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        usr_cmd  = LEFT;
        state    = WAIT;
        level    = 4'd0;
        pause    = 1'b0;
        auto_eng = 1'b1;
        pops     = 0;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (cmd !== NONE) begin mismatched++; $display("[TB] FAIL reset_cmd: got %0d expected %0d", cmd, NONE); end
        compared++;
        if (usr_pop !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_pop: got %0b expected 0", usr_pop); end
        compared++;
        if (grav_pending !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_pending: got %0b expected 0", grav_pending); end
        reset_n = 1'b1;
        step;
        compared++;
        if (cmd !== LEFT) begin mismatched++; $display("[TB] FAIL reset_first_cmd: got %0d expected %0d", cmd, LEFT); end
        compared++;
        if (pops !== 1) begin mismatched++; $display("[TB] FAIL reset_first_pop: got %0d expected 1", pops); end
        step;
        compared++;
        if (usr_pop !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_pop_width: got %0b expected 0", usr_pop); end
        compared++;
        if (cmd !== NONE) begin mismatched++; $display("[TB] FAIL reset_cmd_after_accept: got %0d expected %0d", cmd, NONE); end
    endtask

    task automatic test_gravity;
        start(4'd0);
        for (int cyc = 1; cyc <= 61; cyc++) begin
            step;
            if (cyc % 20 == 19) begin
                compared++;
                if (grav_pending !== 1'b0) begin mismatched++; $display("[TB] FAIL grav_early_c%0d: got %0b expected 0", cyc, grav_pending); end
            end
            if (cyc % 20 == 0) begin
                compared++;
                if (grav_pending !== 1'b1) begin mismatched++; $display("[TB] FAIL grav_tick_c%0d: got %0b expected 1", cyc, grav_pending); end
            end
            if (cyc % 20 == 1 && cyc > 1) begin
                compared++;
                if (cmd !== DOWN) begin mismatched++; $display("[TB] FAIL grav_down_c%0d: got %0d expected %0d", cyc, cmd, DOWN); end
            end
        end
    endtask

    task automatic test_level(input logic [3:0] lvl, input int per);
        start(lvl);
        for (int cyc = 1; cyc <= 2 * per + 1; cyc++) begin
            step;
            if (cyc == per - 1) begin
                compared++;
                if (grav_pending !== 1'b0) begin mismatched++; $display("[TB] FAIL level%0d_early: got %0b expected 0", lvl, grav_pending); end
            end
            if (cyc == per || cyc == 2 * per) begin
                compared++;
                if (grav_pending !== 1'b1) begin mismatched++; $display("[TB] FAIL level%0d_tick_c%0d: got %0b expected 1", lvl, cyc, grav_pending); end
            end
            if (cyc == per + 1) begin
                compared++;
                if (cmd !== DOWN) begin mismatched++; $display("[TB] FAIL level%0d_down: got %0d expected %0d", lvl, cmd, DOWN); end
            end
        end
    endtask

    task automatic test_level_change;
        start(4'd0);
        repeat (15) step;
        level = 4'd4;
        step;
        compared++;
        if (grav_pending !== 1'b0) begin mismatched++; $display("[TB] FAIL lvlchg_early: got %0b expected 0", grav_pending); end
        step;
        compared++;
        if (grav_pending !== 1'b1) begin mismatched++; $display("[TB] FAIL lvlchg_tick: got %0b expected 1", grav_pending); end
        compared++;
        if (dut.u_timer.cnt !== 5'd0) begin mismatched++; $display("[TB] FAIL lvlchg_cnt: got %0d expected 0", dut.u_timer.cnt); end
    endtask

    task automatic test_conflict;
        start(4'd0);
        repeat (20) step;
        compared++;
        if (grav_pending !== 1'b1) begin mismatched++; $display("[TB] FAIL conflict_pending: got %0b expected 1", grav_pending); end
        usr_cmd = ROTATE;
        step;
        compared++;
        if (cmd !== DOWN) begin mismatched++; $display("[TB] FAIL conflict_first: got %0d expected %0d", cmd, DOWN); end
        compared++;
        if (usr_pop !== 1'b0) begin mismatched++; $display("[TB] FAIL conflict_no_pop: got %0b expected 0", usr_pop); end
        repeat (3) step;
        compared++;
        if (cmd !== ROTATE) begin mismatched++; $display("[TB] FAIL conflict_second: got %0d expected %0d", cmd, ROTATE); end
        compared++;
        if (usr_pop !== 1'b1) begin mismatched++; $display("[TB] FAIL conflict_pop: got %0b expected 1", usr_pop); end
        repeat (3) step;
        compared++;
        if (pops !== 1) begin mismatched++; $display("[TB] FAIL conflict_pop_count: got %0d expected 1", pops); end
    endtask

    task automatic test_drop;
        start(4'd0);
        repeat (15) step;
        compared++;
        if (dut.u_timer.cnt !== 5'd15) begin mismatched++; $display("[TB] FAIL drop_cnt_before: got %0d expected 15", dut.u_timer.cnt); end
        usr_cmd = DROP;
        step;
        compared++;
        if (cmd !== DROP) begin mismatched++; $display("[TB] FAIL drop_cmd: got %0d expected %0d", cmd, DROP); end
        compared++;
        if (dut.u_timer.cnt !== 5'd0) begin mismatched++; $display("[TB] FAIL drop_cnt_clear: got %0d expected 0", dut.u_timer.cnt); end
        for (int cyc = 17; cyc <= 36; cyc++) begin
            step;
            if (cyc == 35) begin
                compared++;
                if (grav_pending !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_early: got %0b expected 0", grav_pending); end
            end
            if (cyc == 36) begin
                compared++;
                if (grav_pending !== 1'b1) begin mismatched++; $display("[TB] FAIL drop_next_tick: got %0b expected 1", grav_pending); end
            end
        end
        // A player DOWN issued on the very cycle the timer would tick swallows the tick.
        start(4'd0);
        repeat (19) step;
        usr_cmd = DOWN;
        step;
        compared++;
        if (grav_pending !== 1'b0) begin mismatched++; $display("[TB] FAIL down_discard_pending: got %0b expected 0", grav_pending); end
        compared++;
        if (dut.u_timer.cnt !== 5'd0) begin mismatched++; $display("[TB] FAIL down_discard_cnt: got %0d expected 0", dut.u_timer.cnt); end
    endtask

    task automatic test_pause;
        int issued;
        start(4'd0);
        repeat (10) step;
        pause   = 1'b1;
        usr_cmd = LEFT;
        issued  = 0;
        repeat (50) begin
            step;
            if (cmd != NONE) issued++;
        end
        compared++;
        if (issued !== 0) begin mismatched++; $display("[TB] FAIL pause_issued: got %0d expected 0", issued); end
        compared++;
        if (pops !== 0) begin mismatched++; $display("[TB] FAIL pause_pops: got %0d expected 0", pops); end
        compared++;
        if (dut.u_timer.cnt !== 5'd10) begin mismatched++; $display("[TB] FAIL pause_cnt: got %0d expected 10", dut.u_timer.cnt); end
        usr_cmd = NONE;
        pause   = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            step;
            if (cyc == 9) begin
                compared++;
                if (grav_pending !== 1'b0) begin mismatched++; $display("[TB] FAIL unpause_early: got %0b expected 0", grav_pending); end
            end
            if (cyc == 10) begin
                compared++;
                if (grav_pending !== 1'b1) begin mismatched++; $display("[TB] FAIL unpause_tick: got %0b expected 1", grav_pending); end
            end
        end
    endtask

    task automatic test_reset_in_issue;
        start(4'd0);
        auto_eng = 1'b0;
        repeat (2) step;
        usr_cmd = RIGHT;
        step;
        compared++;
        if (cmd !== RIGHT) begin mismatched++; $display("[TB] FAIL hold_issue: got %0d expected %0d", cmd, RIGHT); end
        repeat (3) step;
        compared++;
        if (cmd !== RIGHT) begin mismatched++; $display("[TB] FAIL hold_stable: got %0d expected %0d", cmd, RIGHT); end
        compared++;
        if (pops !== 1) begin mismatched++; $display("[TB] FAIL hold_pops: got %0d expected 1", pops); end
        reset_n = 1'b0;
        #1;
        compared++;
        if (cmd !== NONE) begin mismatched++; $display("[TB] FAIL async_reset_cmd: got %0d expected %0d", cmd, NONE); end
        compared++;
        if (usr_pop !== 1'b0) begin mismatched++; $display("[TB] FAIL async_reset_pop: got %0b expected 0", usr_pop); end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset;
        test_gravity;
        test_level(4'd5, 8);
        test_level(4'd3, 8);
        test_level(4'd2, 12);
        test_level_change;
        test_conflict;
        test_drop;
        test_pause;
        test_reset_in_issue;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/gravity_sched.md
# gravity_sched

Command scheduler between the input command queue and the Tetris game engine. It merges player commands from the queue head with automatic gravity `DOWN` commands and presents exactly one command at a time to the engine. Each command is held until the engine accepts it. The gravity period shortens with the current level, freezes while paused, and restarts whenever the player moves the piece down.

## Interface
Parameters:
- `BASE_PERIOD`, default 100_000_000: gravity period at level 0, in clk cycles.
- `STEP`, default 6_000_000: period reduction per level.
- `MIN_PERIOD`, default 5_000_000: floor on the gravity period.
- `PW`, default `$clog2(BASE_PERIOD+1)`: width of the period and counter.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `usr_cmd`  in  state_type  command at the queue head; `NONE` means the queue is empty.
- `usr_pop`  out  1  one-cycle pulse; the queue drops its head on the next edge.
- `state`  in  state_type  engine state; `WAIT` means the engine is ready for a command.
- `cmd`  out  state_type  command presented to the engine.
- `level`  in  4  current level, 0..15.
- `pause`  in  1  freezes gravity and blocks new issues.
- `grav_pending`  out  1  a gravity tick is waiting to be issued.

## Operation
- Scheduler FSM (`gs_state_t`) has three states: `IDLE`, `ISSUE`, `BUSY`.
- `IDLE`, pause=0 and state==`WAIT`:
  - If grav_pending: load cmd=`DOWN`, clear grav_pending, go to `ISSUE`.
  - Else if usr_cmd!=`NONE`: load cmd=usr_cmd, pulse usr_pop, go to `ISSUE`.
  - Else stay in `IDLE`.
- Gravity has priority over the player. Gravity and player commands never issue in the same cycle.
- `ISSUE`: hold cmd stable until state!=`WAIT` (engine accepted). Then cmd<=`NONE` and go to `BUSY`.
- `BUSY`: when state==`WAIT`, go to `IDLE`.
- Gravity timer:
  - period = max(BASE_PERIOD − level·STEP, MIN_PERIOD), evaluated at PW+4 bits with no underflow, registered into period_q.
  - cnt increments each cycle while pause=0.
  - When cnt ≥ period_q−1: cnt<=0 and grav_pending<=1. If grav_pending is already 1, the tick is dropped; ticks never count above 1.
- An issued player `DOWN` or `DROP` clears cnt to 0 and clears grav_pending in the issue cycle. Any gravity tick in that same cycle is discarded.
- pause=1:
  - cnt and grav_pending hold.
  - `IDLE` issues nothing.
  - A command already in `ISSUE`/`BUSY` completes normally.
- Reset values (asynchronous, effective immediately):
  - FSM=`IDLE`, cmd=`NONE`, usr_pop=0, grav_pending=0, cnt=0.
  - period_q=BASE_PERIOD.
- Reset mid-`ISSUE`: the command is abandoned. The queue entry is not restored.

## Timing
- Issue latency: usr_cmd valid with state==`WAIT` in `IDLE` at edge N → cmd valid and usr_pop=1 after edge N.
- usr_pop is high for exactly one cycle per issued player command.
- cmd is never `NONE` while in `ISSUE`. cmd is `NONE` in `IDLE` and `BUSY`.
- Minimum spacing between issues is 3 cycles: `ISSUE` → `BUSY` → `IDLE`.
- Gravity tick to `DOWN` issue is 1 cycle if the FSM is in `IDLE` and state==`WAIT`.
- A level change affects the comparison 1 cycle later. If the new period ≤ cnt+1, the tick fires on the next cycle.

## Structure
- `gs_state_t` goes in shared package `enum_type`, next to `state_type`.
- Period constants are parameters only.
- Sub-module `gravity_timer` holds period_q, cnt and grav_pending. Its ports are clk, reset_n, level, pause, clr, take, tick_pending.
- `gravity_sched` keeps the FSM, arbitration and cmd/usr_pop registers.

## Test plan
All scenarios use BASE_PERIOD=20, STEP=4, MIN_PERIOD=8.
- Reset: hold reset_n=0 with usr_cmd=`LEFT` and state=`WAIT` → cmd=`NONE`, usr_pop=0, grav_pending=0. After release, `LEFT` issues 1 cycle later.
- Gravity at level 0, engine idle in `WAIT`, no player input → grav_pending rises every 20 cycles. Each rise is followed by cmd=`DOWN` one cycle later.
- Level 5: 20−20 is clamped to period 8 → `DOWN` every 8 cycles. At level 3 (period 8) the result is the same; at level 2 the period is 12.
- Conflict: usr_cmd=`ROTATE` and a tick in the same cycle → `DOWN` issues first. `ROTATE` issues after the engine returns to `WAIT`. usr_pop pulses once.
- Player `DROP` with cnt=15 at level 0 → cnt=0 and grav_pending=0. The next tick arrives 20 cycles later.
- Pause for 50 cycles with cnt=10 → no cmd, cnt stays 10. After unpause, the tick fires 10 cycles later. Asserting reset during `ISSUE` → cmd=`NONE` immediately.
